pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Central stall/flush/redirect controller for the 5-stage MIPS pipeline. Decides, each cycle, whether the PC and the IF/ID, ID/EX and EX/MEM registers advance, hold or are flushed. It selects the next-PC source from the branch/jump decision carried in the EX/MEM stage and stretches the pipeline around a multi-cycle data memory. It sits beside the pipeline registers and drives their write/flush/hold controls. It also keeps saturating stall and flush statistics.

## Interface
Parameters:
- CNT_W, 16, width of statistics counters
- MEM_TIMEOUT, 64, max cycles waiting on mem_ready before error (≥2)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high
- IFID_rs  in  5  rs field of instruction in IF/ID
- IFID_rt  in  5  rt field of instruction in IF/ID
- IDEX_MemRead  in  1  instruction in ID/EX is a load
- IDEX_rt  in  5  load destination in ID/EX
- EXMEM_Jump, EXMEM_JR, EXMEM_BranchEQ, EXMEM_BranchNE, EXMEM_Zero  in  1 each  control flow info in EX/MEM
- EXMEM_MemRead, EXMEM_MemWrite  in  1 each  memory op in EX/MEM
- mem_ready  in  1  data memory completes access this cycle
- PC_write  out  1  PC loads next value
- IFID_write  out  1  IF/ID loads
- IFID_flush, IDEX_flush, EXMEM_flush  out  1 each  register loads bubble (all zeros)
- pipe_hold  out  1  every pipeline register and PC holds
- PC_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 JR register
- stall_count  out  CNT_W  cycles lost to stalls
- flush_count  out  CNT_W  redirects taken
- mem_error  out  1  sticky memory timeout flag

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Control outputs are combinational from state and inputs. State, wait counter and statistics are registered.
- Defaults in RUN with no event: PC_write=1, IFID_write=1, all flushes 0, pipe_hold=0, PC_src=00.
- Per-cycle priority in RUN: memory hold > redirect > load-use.
- Memory hold: (EXMEM_MemRead|EXMEM_MemWrite) & ~mem_ready. Drives pipe_hold=1, PC_write=0, IFID_write=0, no flushes. Next state is MEM_WAIT and wait_cnt loads 1.
- MEM_WAIT: same outputs as memory hold.
  - If mem_ready=1: outputs revert to RUN evaluation in the same cycle (redirect/load-use may apply). Next state is RUN.
  - Otherwise wait_cnt increments.
  - If wait_cnt = MEM_TIMEOUT-1 with mem_ready still 0: next state is ERROR.
- ERROR: pipe_hold=1, PC_write=0, IFID_write=0, mem_error=1. Only reset exits.
- Redirect: taken = EXMEM_Jump | EXMEM_JR | (EXMEM_BranchEQ & EXMEM_Zero) | (EXMEM_BranchNE & ~EXMEM_Zero).
  - Drives IFID_flush=IDEX_flush=EXMEM_flush=1, PC_write=1.
  - PC_src: JR→11 (highest), else Jump→10, else branch→01.
  - Load-use is suppressed in the same cycle.
- Load-use: IDEX_MemRead & IDEX_rt≠0 & (IDEX_rt==IFID_rs | IDEX_rt==IFID_rt).
  - Drives PC_write=0, IFID_write=0, IDEX_flush=1. Lasts one cycle, because the inserted bubble clears IDEX_MemRead.
- Statistics:
  - stall_count +1 on every cycle with pipe_hold=1 or a load-use stall.
  - flush_count +1 per redirect cycle.
  - Both saturate at all-ones and never wrap.

## Timing
- Zero-latency decisions: controls apply to the edge ending the current cycle.
- Reset cycle (reset=1):
  - All flushes 1, PC_write=0, IFID_write=0, pipe_hold=0, PC_src=00.
  - Next state RUN; counters, wait_cnt and mem_error cleared to 0 at the edge.
- Reset mid-MEM_WAIT or in ERROR returns to RUN with mem_error=0 after one edge.
- mem_ready high on the first memory-op cycle: no hold, no state change, stall_count unchanged.
- Redirect coinciding with a memory op on the same EX/MEM instruction is impossible by ISA; if it is presented, memory hold wins and the redirect is evaluated when mem_ready rises.

## Structure
- Shared package holds:
  - PC_src encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_J, PCSRC_JR)
  - FSM state encoding
  - the bubble convention (all-zero control)
- One sub-module, sat_counter (CNT_W, increment enable, synchronous clear), instantiated twice for the statistics.

## Test plan
- lw $t0 in ID/EX (IDEX_rt=8), IFID_rs=8 → one cycle of PC_write=0, IFID_write=0, IDEX_flush=1; stall_count=1. With IDEX_rt=0 → no stall.
- EXMEM_BranchEQ=1, Zero=1 → PC_src=01, three flushes 1, flush_count=1. BranchEQ=1, Zero=0 → defaults.
- EXMEM_JR=1 and Jump=1 simultaneously with a load-use hazard present → PC_src=11, flushes asserted, no load-use stall.
- EXMEM_MemRead=1, mem_ready low 3 cycles then high → pipe_hold high exactly 3 cycles, stall_count=3, state back to RUN.
- MEM_TIMEOUT=4, mem_ready never rises → ERROR reached after 4 hold cycles, mem_error=1 sticky. Reset → all outputs at reset values, mem_error=0.
- CNT_W=2, 5 redirects → flush_count saturates at 3.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: next-PC source
// encodings, FSM state encoding and the per-cycle control bundle, including
// the all-zero bubble.
package pipeline_hazard_controller_pkg;

   // Next-PC source select
   localparam logic [1:0] PCSRC_SEQ = 2'b00;  // PC+4
   localparam logic [1:0] PCSRC_BR  = 2'b01;  // branch target
   localparam logic [1:0] PCSRC_J   = 2'b10;  // jump target
   localparam logic [1:0] PCSRC_JR  = 2'b11;  // JR register

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } state_t;

   // One cycle's worth of pipeline controls
   typedef struct packed {
      logic       pc_write;
      logic       ifid_write;
      logic       ifid_flush;
      logic       idex_flush;
      logic       exmem_flush;
      logic       pipe_hold;
      logic [1:0] pc_src;
   } ctrl_t;

   // A flushed register loads this: every control bit low
   localparam ctrl_t CTRL_BUBBLE = '0;

   // Free-running pipeline: everything advances sequentially
   localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_write: 1'b1,
                                  ifid_flush: 1'b0, idex_flush: 1'b0,
                                  exmem_flush: 1'b0, pipe_hold: 1'b0,
                                  pc_src: PCSRC_SEQ};

   // Whole pipeline frozen behind the data memory
   localparam ctrl_t CTRL_HOLD = '{pc_write: 1'b0, ifid_write: 1'b0,
                                   ifid_flush: 1'b0, idex_flush: 1'b0,
                                   exmem_flush: 1'b0, pipe_hold: 1'b1,
                                   pc_src: PCSRC_SEQ};

   // Reset cycle: load bubbles everywhere, keep the PC
   localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0,
                                    ifid_flush: 1'b1, idex_flush: 1'b1,
                                    exmem_flush: 1'b1, pipe_hold: 1'b0,
                                    pc_src: PCSRC_SEQ};

   // Redirect target priority: JR over Jump over branch
   function automatic logic [1:0] redirect_src(input logic jr, input logic jump);
      if (jr)
         return PCSRC_JR;
      else if (jump)
         return PCSRC_J;
      else
         return PCSRC_BR;
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat.sv
// sat_counter: saturating up-counter used for pipeline statistics.
// Ports: clk, clear (synchronous, wins over inc), inc (count enable), count.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear)
         count <= '0;
      else if (inc && (count != {CNT_W{1'b1}}))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/redirect controller for the 5-stage pipeline: decides per cycle
// whether PC, IF/ID, ID/EX and EX/MEM advance, hold or load a bubble, picks
// the next-PC source and stretches the pipe around a slow data memory.
// Ports: hazard/control-flow/memory inputs from the pipeline registers; PC and
// register write/flush/hold controls, PC_src, stall/flush statistics, mem_error.
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       IFID_rs,
   input  logic [4:0]       IFID_rt,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       IDEX_rt,
   input  logic             EXMEM_Jump,
   input  logic             EXMEM_JR,
   input  logic             EXMEM_BranchEQ,
   input  logic             EXMEM_BranchNE,
   input  logic             EXMEM_Zero,
   input  logic             EXMEM_MemRead,
   input  logic             EXMEM_MemWrite,
   input  logic             mem_ready,
   output logic             PC_write,
   output logic             IFID_write,
   output logic             IFID_flush,
   output logic             IDEX_flush,
   output logic             EXMEM_flush,
   output logic             pipe_hold,
   output logic [1:0]       PC_src,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic             mem_error
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            state;
   state_t            next_state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              mem_error_q;

   logic  mem_busy;
   logic  taken;
   logic  load_use;
   ctrl_t run_ctl;
   logic  run_redirect;
   logic  run_load_use;
   ctrl_t ctl;
   logic  redirect_cyc;
   logic  load_use_cyc;

   assign mem_busy = (EXMEM_MemRead | EXMEM_MemWrite) & ~mem_ready;
   assign taken    = EXMEM_Jump | EXMEM_JR |
                     (EXMEM_BranchEQ & EXMEM_Zero) |
                     (EXMEM_BranchNE & ~EXMEM_Zero);
   assign load_use = IDEX_MemRead && (IDEX_rt != 5'd0) &&
                     ((IDEX_rt == IFID_rs) || (IDEX_rt == IFID_rt));

   // Free-running evaluation, shared by RUN and by the MEM_WAIT cycle in
   // which the memory finally answers (mem_busy is then necessarily low).
   always_comb begin
      run_ctl      = CTRL_RUN;
      run_redirect = 1'b0;
      run_load_use = 1'b0;
      if (mem_busy) begin
         run_ctl = CTRL_HOLD;
      end else if (taken) begin
         run_redirect        = 1'b1;
         run_ctl.ifid_flush  = 1'b1;
         run_ctl.idex_flush  = 1'b1;
         run_ctl.exmem_flush = 1'b1;
         run_ctl.pc_write    = 1'b1;
         run_ctl.pc_src      = redirect_src(EXMEM_JR, EXMEM_Jump);
      end else if (load_use) begin
         // Bubble into ID/EX clears IDEX_MemRead, so this lasts one cycle
         run_load_use       = 1'b1;
         run_ctl.pc_write   = 1'b0;
         run_ctl.ifid_write = 1'b0;
         run_ctl.idex_flush = 1'b1;
      end
   end

   always_comb begin
      ctl          = CTRL_RUN;
      next_state   = state;
      redirect_cyc = 1'b0;
      load_use_cyc = 1'b0;
      if (reset) begin
         ctl        = CTRL_RESET;
         next_state = ST_RUN;
      end else begin
         unique case (state)
            ST_RUN: begin
               ctl          = run_ctl;
               redirect_cyc = run_redirect;
               load_use_cyc = run_load_use;
               if (mem_busy)
                  next_state = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
               if (mem_ready) begin
                  ctl          = run_ctl;
                  redirect_cyc = run_redirect;
                  load_use_cyc = run_load_use;
                  next_state   = ST_RUN;
               end else begin
                  ctl = CTRL_HOLD;
                  if (wait_cnt == WAIT_LAST)
                     next_state = ST_ERROR;
               end
            end
            ST_ERROR: begin
               ctl = CTRL_HOLD;
            end
            default: begin
               ctl        = CTRL_HOLD;
               next_state = ST_ERROR;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_RUN;
         wait_cnt    <= '0;
         mem_error_q <= 1'b0;
      end else begin
         state <= next_state;
         if (state == ST_RUN && mem_busy)
            wait_cnt <= WAIT_W'(1);
         else if (state == ST_MEM_WAIT && !mem_ready)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
         if (next_state == ST_ERROR)
            mem_error_q <= 1'b1;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (ctl.pipe_hold | load_use_cyc),
      .count (stall_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (redirect_cyc),
      .count (flush_count)
   );

   assign PC_write    = ctl.pc_write;
   assign IFID_write  = ctl.ifid_write;
   assign IFID_flush  = ctl.ifid_flush;
   assign IDEX_flush  = ctl.idex_flush;
   assign EXMEM_flush = ctl.exmem_flush;
   assign pipe_hold   = ctl.pipe_hold;
   assign PC_src      = ctl.pc_src;
   assign mem_error   = mem_error_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] IFID_rs = '0, IFID_rt = '0, IDEX_rt = '0;
   logic       IDEX_MemRead = 1'b0;
   logic       EXMEM_Jump = 1'b0, EXMEM_JR = 1'b0, EXMEM_BranchEQ = 1'b0;
   logic       EXMEM_BranchNE = 1'b0, EXMEM_Zero = 1'b0;
   logic       EXMEM_MemRead = 1'b0, EXMEM_MemWrite = 1'b0, mem_ready = 1'b0;

   logic        PC_write, IFID_write, IFID_flush, IDEX_flush, EXMEM_flush, pipe_hold;
   logic [1:0]  PC_src;
   logic [15:0] stall_count, flush_count;
   logic        mem_error;

   logic        s_PC_write, s_IFID_write, s_IFID_flush, s_IDEX_flush, s_EXMEM_flush, s_pipe_hold;
   logic [1:0]  s_PC_src;
   logic [1:0]  s_stall_count, s_flush_count;
   logic        s_mem_error;

   always #5 clk = ~clk;

   pipeline_hazard_controller #(.CNT_W(16), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt),
      .EXMEM_Jump(EXMEM_Jump), .EXMEM_JR(EXMEM_JR),
      .EXMEM_BranchEQ(EXMEM_BranchEQ), .EXMEM_BranchNE(EXMEM_BranchNE),
      .EXMEM_Zero(EXMEM_Zero), .EXMEM_MemRead(EXMEM_MemRead),
      .EXMEM_MemWrite(EXMEM_MemWrite), .mem_ready(mem_ready),
      .PC_write(PC_write), .IFID_write(IFID_write),
      .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .EXMEM_flush(EXMEM_flush),
      .pipe_hold(pipe_hold), .PC_src(PC_src),
      .stall_count(stall_count), .flush_count(flush_count), .mem_error(mem_error)
   );

   // Narrow-counter instance on the same stimulus, for saturation
   pipeline_hazard_controller #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_small (
      .clk(clk), .reset(reset),
      .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt),
      .EXMEM_Jump(EXMEM_Jump), .EXMEM_JR(EXMEM_JR),
      .EXMEM_BranchEQ(EXMEM_BranchEQ), .EXMEM_BranchNE(EXMEM_BranchNE),
      .EXMEM_Zero(EXMEM_Zero), .EXMEM_MemRead(EXMEM_MemRead),
      .EXMEM_MemWrite(EXMEM_MemWrite), .mem_ready(mem_ready),
      .PC_write(s_PC_write), .IFID_write(s_IFID_write),
      .IFID_flush(s_IFID_flush), .IDEX_flush(s_IDEX_flush), .EXMEM_flush(s_EXMEM_flush),
      .pipe_hold(s_pipe_hold), .PC_src(s_PC_src),
      .stall_count(s_stall_count), .flush_count(s_flush_count), .mem_error(s_mem_error)
   );

   // Control vector order: {PC_write, IFID_write, IFID_flush, IDEX_flush, EXMEM_flush, pipe_hold, PC_src}
   localparam logic [7:0] K_RST  = 8'b00_111_0_00;
   localparam logic [7:0] K_DEF  = 8'b11_000_0_00;
   localparam logic [7:0] K_LU   = 8'b00_010_0_00;
   localparam logic [7:0] K_HOLD = 8'b00_000_1_00;
   localparam logic [7:0] K_BR   = 8'b11_111_0_01;
   localparam logic [7:0] K_J    = 8'b11_111_0_10;
   localparam logic [7:0] K_JR   = 8'b11_111_0_11;

   // EX/MEM flag order: {Jump, JR, BranchEQ, BranchNE, Zero, MemRead, MemWrite, mem_ready}
   localparam logic [7:0] C_NONE = 8'b0000_0000;
   localparam logic [7:0] C_J    = 8'b1000_0000;
   localparam logic [7:0] C_JR   = 8'b0100_0000;
   localparam logic [7:0] C_BEQ  = 8'b0010_0000;
   localparam logic [7:0] C_BNE  = 8'b0001_0000;
   localparam logic [7:0] C_Z    = 8'b0000_1000;
   localparam logic [7:0] C_MR   = 8'b0000_0100;
   localparam logic [7:0] C_MW   = 8'b0000_0010;
   localparam logic [7:0] C_RDY  = 8'b0000_0001;

   typedef struct packed {
      logic [7:0]  ctl;
      logic [15:0] stall;
      logic [15:0] flush;
      logic        err;
      logic [1:0]  sflush;
   } obs_t;

   obs_t   exp_q[$];
   string  name_q[$];
   logic   sample_req = 1'b0;
   int     checks = 0;
   int     errors = 0;

   // Monitor: whenever a vector is presented, pop its expectation and compare
   always @(negedge clk) begin
      if (sample_req) begin
         obs_t  act, exp_v;
         string nm;
         act = '{ctl: {PC_write, IFID_write, IFID_flush, IDEX_flush, EXMEM_flush, pipe_hold, PC_src},
                 stall: stall_count, flush: flush_count, err: mem_error, sflush: s_flush_count};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL no_expectation: scoreboard empty while vector presented");
         end else begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            if (act !== exp_v) begin
               errors++;
               $display("FAIL %s: got ctl=%b stall=%0d flush=%0d err=%b sflush=%0d, want ctl=%b stall=%0d flush=%0d err=%b sflush=%0d",
                        nm, act.ctl, act.stall, act.flush, act.err, act.sflush,
                        exp_v.ctl, exp_v.stall, exp_v.flush, exp_v.err, exp_v.sflush);
            end
         end
      end
   end

   task automatic vec(input string nm, input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic imr, input logic [4:0] irt, input logic [7:0] cf,
                      input logic [7:0] e_ctl, input int e_stall, input int e_flush,
                      input logic e_err, input int e_sflush);
      obs_t e;
      reset   = rst;
      IFID_rs = rs;
      IFID_rt = rt;
      IDEX_MemRead = imr;
      IDEX_rt = irt;
      {EXMEM_Jump, EXMEM_JR, EXMEM_BranchEQ, EXMEM_BranchNE, EXMEM_Zero,
       EXMEM_MemRead, EXMEM_MemWrite, mem_ready} = cf;
      e = '{ctl: e_ctl, stall: 16'(e_stall), flush: 16'(e_flush), err: e_err, sflush: 2'(e_sflush)};
      exp_q.push_back(e);
      name_q.push_back(nm);
      sample_req = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      //   name           rst rs rt imr irt flags                  ctl    stall flush err sflush
      vec("reset",        1, 0, 0, 0, 0, C_NONE,                 K_RST,  0, 0, 0, 0);
      vec("idle",         0, 0, 0, 0, 0, C_NONE,                 K_DEF,  0, 0, 0, 0);
      vec("lu_rs",        0, 8, 0, 1, 8, C_NONE,                 K_LU,   0, 0, 0, 0);
      vec("after_lu",     0, 0, 0, 0, 0, C_NONE,                 K_DEF,  1, 0, 0, 0);
      vec("lu_rt_zero",   0, 0, 0, 1, 0, C_NONE,                 K_DEF,  1, 0, 0, 0);
      vec("lu_rt",        0, 0, 9, 1, 9, C_NONE,                 K_LU,   1, 0, 0, 0);
      vec("beq_taken",    0, 0, 0, 0, 0, C_BEQ | C_Z,            K_BR,   2, 0, 0, 0);
      vec("beq_not",      0, 0, 0, 0, 0, C_BEQ,                  K_DEF,  2, 1, 0, 1);
      vec("bne_taken",    0, 0, 0, 0, 0, C_BNE,                  K_BR,   2, 1, 0, 1);
      vec("jr_j_lu",      0, 8, 0, 1, 8, C_JR | C_J,             K_JR,   2, 2, 0, 2);
      vec("jump",         0, 0, 0, 0, 0, C_J,                    K_J,    2, 3, 0, 3);
      vec("mem_hold1",    0, 0, 0, 0, 0, C_MR,                   K_HOLD, 2, 4, 0, 3);
      vec("mem_hold2",    0, 0, 0, 0, 0, C_MR,                   K_HOLD, 3, 4, 0, 3);
      vec("mem_hold3",    0, 0, 0, 0, 0, C_MR,                   K_HOLD, 4, 4, 0, 3);
      vec("mem_ready",    0, 0, 0, 0, 0, C_MR | C_RDY,           K_DEF,  5, 4, 0, 3);
      vec("back_in_run",  0, 0, 0, 0, 0, C_NONE,                 K_DEF,  5, 4, 0, 3);
      vec("mem_fast",     0, 0, 0, 0, 0, C_MR | C_RDY,           K_DEF,  5, 4, 0, 3);
      vec("after_fast",   0, 0, 0, 0, 0, C_NONE,                 K_DEF,  5, 4, 0, 3);
      vec("memw_over_br", 0, 0, 0, 0, 0, C_MW | C_BEQ | C_Z,     K_HOLD, 5, 4, 0, 3);
      vec("br_on_ready",  0, 0, 0, 0, 0, C_MW | C_BEQ | C_Z | C_RDY, K_BR, 6, 4, 0, 3);
      vec("after_br",     0, 0, 0, 0, 0, C_NONE,                 K_DEF,  6, 5, 0, 3);
      vec("timeout1",     0, 0, 0, 0, 0, C_MR,                   K_HOLD, 6, 5, 0, 3);
      vec("timeout2",     0, 0, 0, 0, 0, C_MR,                   K_HOLD, 7, 5, 0, 3);
      vec("timeout3",     0, 0, 0, 0, 0, C_MR,                   K_HOLD, 8, 5, 0, 3);
      vec("timeout4",     0, 0, 0, 0, 0, C_MR,                   K_HOLD, 9, 5, 0, 3);
      vec("error",        0, 0, 0, 0, 0, C_MR,                   K_HOLD, 10, 5, 1, 3);
      vec("error_sticky", 0, 0, 0, 0, 0, C_RDY,                  K_HOLD, 11, 5, 1, 3);
      vec("reset_in_err", 1, 0, 0, 0, 0, C_NONE,                 K_RST,  12, 5, 1, 3);
      vec("post_reset",   0, 0, 0, 0, 0, C_NONE,                 K_DEF,  0, 0, 0, 0);
      sample_req = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
